// File: rtl/regfile_dumper.sv
// Streams the contents of a two-read-port register file, one pair per fetch,
// over a valid/ready word interface with a one-cycle done pulse at the end.
module regfile_dumper #(
  parameter int LAST_REG = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  outIndex,
  output logic [31:0] outData,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  p;
  logic [4:0]  p_nxt;
  logic [31:0] buf_a;
  logic [31:0] buf_a_nxt;
  logic [31:0] buf_b;
  logic [31:0] buf_b_nxt;
  logic        valid_nxt;
  logic [4:0]  index_nxt;
  logic [31:0] data_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        xfer;

  assign readReg1 = p;
  assign readReg2 = p + 5'd1;
  assign xfer     = outValid & outReady;

  // Next-state, pair pointer and snapshot buffers.
  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    buf_a_nxt = buf_a;
    buf_b_nxt = buf_b;
    case (state)
      IDLE: begin
        p_nxt = 5'd0;
        if (start) begin
          state_nxt = FETCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      FETCH: begin
        buf_a_nxt = readData1;
        buf_b_nxt = readData2;
        state_nxt = SEND_A;
      end
      SEND_A: begin
        if (xfer) begin
          state_nxt = SEND_B;
        end else begin
          state_nxt = SEND_A;
        end
      end
      SEND_B: begin
        if (xfer && (p + 5'd1 == LAST_IDX)) begin
          state_nxt = DONE;
        end else if (xfer) begin
          p_nxt     = p + 5'd2;
          state_nxt = FETCH;
        end else begin
          state_nxt = SEND_B;
        end
      end
      DONE: begin
        p_nxt     = 5'd0;
        state_nxt = IDLE;
      end
      default: begin
        p_nxt     = 5'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    valid_nxt = 1'b0;
    index_nxt = 5'd0;
    data_nxt  = 32'd0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      FETCH: begin
        busy_nxt = 1'b1;
      end
      SEND_A: begin
        valid_nxt = 1'b1;
        index_nxt = p_nxt;
        data_nxt  = buf_a_nxt;
        busy_nxt  = 1'b1;
      end
      SEND_B: begin
        valid_nxt = 1'b1;
        index_nxt = p_nxt + 5'd1;
        data_nxt  = buf_b_nxt;
        busy_nxt  = 1'b1;
      end
      DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // State, pointer, buffers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      p        <= 5'd0;
      buf_a    <= 32'd0;
      buf_b    <= 32'd0;
      outValid <= 1'b0;
      outIndex <= 5'd0;
      outData  <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      p        <= p_nxt;
      buf_a    <= buf_a_nxt;
      buf_b    <= buf_b_nxt;
      outValid <= valid_nxt;
      outIndex <= index_nxt;
      outData  <= data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: a full-size and a 4-register instance share one
// register-file array and are checked every cycle against a word-level model.
module tb_regfile_dumper;

  localparam int L0 = 31;
  localparam int L1 = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] regs [32];

  logic        start0, ready0, v0, busy0, done0;
  logic [4:0]  rr1_0, rr2_0, idx0;
  logic [31:0] rd1_0, rd2_0, data0;
  logic        start1, ready1, v1, busy1, done1;
  logic [4:0]  rr1_1, rr2_1, idx1;
  logic [31:0] rd1_1, rd2_1, data1;

  assign rd1_0 = regs[rr1_0];
  assign rd2_0 = regs[rr2_0];
  assign rd1_1 = regs[rr1_1];
  assign rd2_1 = regs[rr2_1];

  always #5 clock = ~clock;

  regfile_dumper #(.LAST_REG(L0)) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .readReg1(rr1_0), .readReg2(rr2_0), .readData1(rd1_0), .readData2(rd2_0),
    .outValid(v0), .outReady(ready0), .outIndex(idx0), .outData(data0),
    .busy(busy0), .done(done0)
  );

  regfile_dumper #(.LAST_REG(L1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .readReg1(rr1_1), .readReg2(rr2_1), .readData1(rd1_1), .readData2(rd2_1),
    .outValid(v1), .outReady(ready1), .outIndex(idx1), .outData(data1),
    .busy(busy1), .done(done1)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          at;
  } xfer_t;

  xfer_t log0[$];
  xfer_t log1[$];
  int    tests = 0;
  int    failed = 0;
  int    cyc = 0;
  int    done_cnt[2] = '{0, 0};
  int    done_cyc[2] = '{0, 0};

  // Word-level model: which word is next, whether a pair fetch is pending, and the pair snapshot.
  bit          m_active[2] = '{0, 0};
  bit          m_fetch[2]  = '{0, 0};
  bit          m_done[2]   = '{0, 0};
  int          m_word[2]   = '{0, 0};
  logic [31:0] m_sa[2]     = '{32'd0, 32'd0};
  logic [31:0] m_sb[2]     = '{32'd0, 32'd0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear(int i);
    m_active[i] = 1'b0;
    m_fetch[i]  = 1'b0;
    m_done[i]   = 1'b0;
    m_word[i]   = 0;
    m_sa[i]     = 32'd0;
    m_sb[i]     = 32'd0;
  endtask

  task automatic model_step(int i, int last, logic st, logic rdy);
    if (m_done[i]) begin
      m_done[i] = 1'b0;
    end else if (!m_active[i]) begin
      if (st) begin
        m_active[i] = 1'b1;
        m_word[i]   = 0;
        m_fetch[i]  = 1'b1;
      end
    end else if (m_fetch[i]) begin
      m_sa[i]    = regs[m_word[i]];
      m_sb[i]    = regs[m_word[i] + 1];
      m_fetch[i] = 1'b0;
    end else if (rdy) begin
      if (m_word[i] == last) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b1;
      end else begin
        m_word[i]++;
        if (m_word[i] % 2 == 0) m_fetch[i] = 1'b1;
      end
    end
  endtask

  task automatic cmp(int i, int last, logic v, logic [4:0] idx, logic [31:0] data,
                     logic b, logic d, logic [4:0] r1, logic [4:0] r2);
    logic        ev, eb, ed;
    logic [31:0] eidx, edata, erp;
    if (reset) begin
      ev = 1'b0; eidx = 32'd0; edata = 32'd0; eb = 1'b0; ed = 1'b0; erp = 32'd0;
    end else begin
      ev    = m_active[i] && !m_fetch[i];
      eidx  = ev ? 32'(m_word[i]) : 32'd0;
      edata = ev ? ((m_word[i] % 2 == 0) ? m_sa[i] : m_sb[i]) : 32'd0;
      eb    = m_active[i];
      ed    = m_done[i];
      erp   = m_done[i] ? 32'(last - 1) : (m_active[i] ? 32'(m_word[i] - m_word[i] % 2) : 32'd0);
    end
    check($sformatf("i%0d outValid", i), 32'(v), 32'(ev));
    check($sformatf("i%0d outIndex", i), 32'(idx), eidx);
    check($sformatf("i%0d outData", i), data, edata);
    check($sformatf("i%0d busy", i), 32'(b), 32'(eb));
    check($sformatf("i%0d done", i), 32'(d), 32'(ed));
    check($sformatf("i%0d readReg1", i), 32'(r1), erp);
    check($sformatf("i%0d readReg2", i), 32'(r2), erp + 32'd1);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0, L0, start0, ready0);
      model_step(1, L1, start1, ready1);
    end
  end

  // Compare every cycle on the falling edge and log DUT transfers.
  initial forever begin
    @(negedge clock);
    cmp(0, L0, v0, idx0, data0, busy0, done0, rr1_0, rr2_0);
    cmp(1, L1, v1, idx1, data1, busy1, done1, rr1_1, rr2_1);
    if (!reset && v0 && ready0) log0.push_back('{int'(idx0), data0, cyc + 1});
    if (!reset && v1 && ready1) log1.push_back('{int'(idx1), data1, cyc + 1});
    if (!reset && done0) begin done_cnt[0]++; done_cyc[0] = cyc; end
    if (!reset && done1) begin done_cnt[1]++; done_cyc[1] = cyc; end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload_ramp();
    for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h01010101;
  endtask

  // mode: 0 plain, 1 backpressure at 0x15, 2 start while busy, 3 snapshot write,
  // 4 reset at word 10, 5 random register writes during the dump.
  task automatic run_main(int mode, int pct, output int acc);
    int dc0, hold;
    bit did;
    log0.delete();
    dc0 = done_cnt[0];
    hold = 0;
    did = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    acc = cyc;
    for (int k = 0; k < 600 && done_cnt[0] == dc0; k++) begin
      ready0 = ($urandom_range(99) < pct);
      if (mode == 1 && v0 && idx0 == 5'h15 && hold < 5) begin
        ready0 = 1'b0;
        hold++;
        check("bp hold index", 32'(idx0), 32'h15);
        check("bp hold data", data0, 32'hffff0000);
      end
      if (mode == 2 && v0 && idx0 == 5'd7 && !did) begin
        start0 = 1'b1;
        did = 1'b1;
      end else begin
        start0 = 1'b0;
      end
      if (mode == 3 && v0 && idx0 == 5'd0 && !did) begin
        regs[10] = 32'h0000ffff;
        did = 1'b1;
      end
      if (mode == 5 && $urandom_range(2) == 0) regs[$urandom_range(31)] = $urandom;
      if (mode == 4 && v0 && idx0 == 5'd10) begin
        reset = 1'b1;
        #1;
        check("mid reset outValid", 32'(v0), 32'd0);
        check("mid reset busy", 32'(busy0), 32'd0);
        check("mid reset done", 32'(done0), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        did = 1'b1;
        break;
      end
      tick();
    end
    start0 = 1'b0;
    repeat (3) tick();
    if (mode == 4) begin
      check("mid reset reached", 32'(did), 32'd1);
      check("mid reset no done", 32'(done_cnt[0] - dc0), 32'd0);
    end else begin
      check("main done count", 32'(done_cnt[0] - dc0), 32'd1);
      check("main word count", 32'(log0.size()), 32'd32);
    end
  endtask

  task automatic run_small(int pct, output int acc);
    int dc1;
    log1.delete();
    dc1 = done_cnt[1];
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    acc = cyc;
    for (int k = 0; k < 200 && done_cnt[1] == dc1; k++) begin
      ready1 = ($urandom_range(99) < pct);
      tick();
    end
    repeat (3) tick();
    check("small done count", 32'(done_cnt[1] - dc1), 32'd1);
    check("small word count", 32'(log1.size()), 32'd4);
  endtask

  initial begin
    int acc;
    int pos;
    int n21;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    ready0 = 1'b0;
    ready1 = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset readReg2", 32'(rr2_0), 32'd1);
    check("reset outValid", 32'(v0), 32'd0);

    // Full dump with the sink always ready.
    preload_ramp();
    run_main(0, 100, acc);
    if (log0.size() == 32) begin
      for (int k = 0; k < 32; k++) begin
        check($sformatf("full index %0d", k), 32'(log0[k].idx), 32'(k));
        check($sformatf("full data %0d", k), log0[k].data, 32'(k) * 32'h01010101);
      end
      check("full word0 data", log0[0].data, 32'd0);
      check("full first transfer edge", 32'(log0[0].at - acc), 32'd2);
      check("full last transfer edge", 32'(log0[31].at - acc), 32'd48);
    end
    check("full done cycle", 32'(done_cyc[0] - acc), 32'd48);

    // Register write while pair 0/1 is being sent lands in the later pair.
    preload_ramp();
    run_main(3, 100, acc);
    if (log0.size() == 32) begin
      check("snapshot word 10", log0[10].data, 32'h0000ffff);
      check("snapshot word 11", log0[11].data, 32'h0b0b0b0b);
    end

    // Backpressure on word 0x15.
    preload_ramp();
    regs[21] = 32'hffff0000;
    run_main(1, 100, acc);
    n21 = 0;
    pos = -1;
    foreach (log0[k]) if (log0[k].idx == 21) begin n21++; pos = k; end
    check("bp word 0x15 transfers", 32'(n21), 32'd1);
    if (pos >= 0 && pos + 1 < log0.size()) check("bp next index", 32'(log0[pos + 1].idx), 32'h16);
    if (pos >= 0) check("bp word 0x15 data", log0[pos].data, 32'hffff0000);
    check("bp last transfer edge", 32'(log0[log0.size() - 1].at - acc), 32'd53);

    // Start while busy is ignored.
    preload_ramp();
    run_main(2, 100, acc);
    if (log0.size() == 32) begin
      for (int k = 0; k < 32; k++) check($sformatf("busy-start index %0d", k), 32'(log0[k].idx), 32'(k));
    end
    check("busy-start still idle", 32'(busy0), 32'd0);

    // Reset mid-dump, then a fresh dump restarts at register 0.
    run_main(4, 100, acc);
    run_main(0, 100, acc);
    if (log0.size() > 0) check("restart first index", 32'(log0[0].idx), 32'd0);

    // Randomised contents, backpressure and concurrent register writes.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      run_main((r % 2 == 0) ? 0 : 5, 40 + 15 * r, acc);
    end

    // Short dump on the 4-register instance.
    preload_ramp();
    run_small(100, acc);
    if (log1.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("small index %0d", k), 32'(log1[k].idx), 32'(k));
      check("small data 3", log1[3].data, 32'h03030303);
      check("small last transfer edge", 32'(log1[3].at - acc), 32'd6);
    end
    check("small done cycle", 32'(done_cyc[1] - acc), 32'd6);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      run_small(50, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The block SHALL have parameter LAST_REG, default 31, meaning the index of the last register dumped; it must be odd, range 1..31.
REQ-002 The block SHALL have port clock, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, meaning a request to begin a dump; sampled only in IDLE.
REQ-005 The block SHALL have port readReg1, output, 5, meaning the register-file read address for port 1.
REQ-006 The block SHALL have port readReg2, output, 5, meaning the register-file read address for port 2.
REQ-007 The block SHALL have port readData1, input, 32, meaning the combinational read data for readReg1.
REQ-008 The block SHALL have port readData2, input, 32, meaning the combinational read data for readReg2.
REQ-009 The block SHALL have port outValid, output, 1, meaning outIndex/outData hold a valid word.
REQ-010 The block SHALL have port outReady, input, 1, meaning the sink accepts the word; a transfer occurs on an edge where outValid=1 and outReady=1.
REQ-011 The block SHALL have port outIndex, output, 5, meaning the register number of the current word.
REQ-012 The block SHALL have port outData, output, 32, meaning the register value of the current word.
REQ-013 The block SHALL have port busy, output, 1, meaning a dump is in progress (FETCH, SEND_A or SEND_B).
REQ-014 The block SHALL have port done, output, 1, meaning a one-cycle pulse after the last word transfers.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, SEND_A, SEND_B and DONE, plus a 5-bit pair pointer p and two 32-bit buffers bufA and bufB.
REQ-016 The block SHALL drive readReg1=p and readReg2=p+1 continuously; p=0 in IDLE.
REQ-017 In IDLE, start=1 at an edge SHALL move the FSM to FETCH with p=0; otherwise the FSM remains in IDLE.
REQ-018 In FETCH, the next edge SHALL capture readData1 into bufA and readData2 into bufB, then move to SEND_A (one cycle, unconditional).
REQ-019 In SEND_A, outputs SHALL be outValid=1, outIndex=p and outData=bufA; on transfer, move to SEND_B.
REQ-020 In SEND_B, outputs SHALL be outValid=1, outIndex=p+1 and outData=bufB; on transfer, if p+1==LAST_REG move to DONE, else set p=p+2 and move to FETCH.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle; the FSM then moves to IDLE, with no transfer possible.
REQ-022 While outValid=1 and outReady=0, outIndex and outData SHALL hold stable and no word SHALL be skipped or repeated.
REQ-023 outValid SHALL be 0 in IDLE, FETCH and DONE, and outIndex/outData SHALL be 0 in those states.
REQ-024 start SHALL be ignored in every state except IDLE; no queuing.
REQ-025 Throughput with outReady held 1 SHALL be 3 cycles per register pair; for LAST_REG=31 the first word is valid 2 edges after start is accepted, the last transfer is 48 edges after acceptance, and done asserts on the following cycle.
REQ-026 Values SHALL be snapshotted per pair at the FETCH edge; register-file writes after that edge do not affect that pair, but do affect later pairs.
REQ-027 Pointer arithmetic SHALL be 5-bit unsigned; p never exceeds LAST_REG-1, so p+1 never wraps.

Reset
REQ-028 While reset=1, the block SHALL asynchronously set the FSM to IDLE, p=0, bufA=bufB=0, outValid=0, busy=0, done=0, outIndex=0, outData=0, readReg1=0 and readReg2=1.
REQ-029 Reset asserted mid-dump SHALL abort the dump immediately, with no done pulse; after release, a new start SHALL restart from register 0.

Verification
REQ-030 A bench SHALL run a full dump: preload reg k=k*0x01010101 (reg0=0), then pulse start with outReady=1 -> indices 0..31 in order, data matches, outData=0 at index 0, single done pulse 49 cycles after acceptance.
REQ-031 A bench SHALL check backpressure: preload reg 0x15=0xffff0000, hold outReady=0 for 5 cycles while outIndex=0x15 -> outIndex/outData stable at 0x15/0xffff0000, then transfers once and proceeds to 0x16.
REQ-032 A bench SHALL check start while busy: pulse start again at word 7 -> sequence unaffected, exactly 32 transfers, one done.
REQ-033 A bench SHALL check mid-dump reset: assert reset while outIndex=10 -> outValid=0 and busy=0 within the reset cycle, no done; after release, start -> first word index 0.
REQ-034 A bench SHALL check a short dump: LAST_REG=3 -> exactly 4 words (0..3), last transfer 6 edges after acceptance, done next cycle.
REQ-035 A bench SHALL check snapshot timing: write reg 0x0A=0x0000ffff while pair 0/1 is in SEND_A -> word 0x0A reports 0x0000ffff.
